// File: rtl/draw_arbiter_pkg.sv
// Shared definitions for the draw-engine arbiter: requester indices, watchdog
// default, FSM encoding and a one-hot to index helper.
package draw_arbiter_pkg;

    localparam int NUM_REQ  = 4;
    localparam int COORD_W  = 10;
    localparam int COLOUR_W = 3;
    localparam int CNT_W    = 20;

    localparam logic [CNT_W-1:0] TIMEOUT_DEFAULT = 20'd1024;

    localparam logic [1:0] REQ_LOADER      = 2'd0;
    localparam logic [1:0] REQ_BRICK_ERASE = 2'd1;
    localparam logic [1:0] REQ_BALL        = 2'd2;
    localparam logic [1:0] REQ_PADDLE      = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/draw_arb_pick.sv
// Combinational winner select: first set request at or after the priority
// pointer (wrapping), returned one-hot.
module draw_arb_pick
    import draw_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [1:0]         i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_any
);

    logic [1:0] w_idx;
    logic       w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = i_ptr + 2'(k);
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/draw_arbiter.sv
// Arbitrates four drawing clients onto one shared draw engine with a watchdog.
// Define DRAW_ARB_ROUNDROBIN_EN for round-robin; otherwise fixed priority (loader first).
module draw_arbiter
    import draw_arbiter_pkg::*;
#(
    parameter logic [CNT_W-1:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [4*COORD_W-1:0]  req_x,
    input  logic [4*COORD_W-1:0]  req_y,
    input  logic [4*COLOUR_W-1:0] req_colour,
    input  logic                  draw_done,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic                  draw_start,
    output logic [COORD_W-1:0]    draw_x,
    output logic [COORD_W-1:0]    draw_y,
    output logic [COLOUR_W-1:0]   draw_colour,
    output logic                  timeout_err,
    output state_t                dbg_state
);

    state_t               r_state, w_next_state;
    logic [NUM_REQ-1:0]   r_gnt, r_done, w_gnt_d, w_done_d;
    logic                 r_start, w_start_d, r_err, w_err_d;
    logic [COORD_W-1:0]   r_x, r_y, w_x_d, w_y_d;
    logic [COLOUR_W-1:0]  r_colour, w_colour_d;
    logic [CNT_W-1:0]     r_cnt, w_cnt_d;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic                 w_pick_any, w_timeout;
    logic [1:0]           w_pick_idx, w_ptr;

`ifdef DRAW_ARB_ROUNDROBIN_EN
    logic [1:0] r_ptr;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                    r_ptr <= '0;
        else if (r_state == S_RELEASE)  r_ptr <= onehot_to_idx(r_gnt) + 2'd1;
    end
    assign w_ptr = r_ptr;
`else
    assign w_ptr = 2'd0;
`endif

    draw_arb_pick u_pick (
        .i_req (req),
        .i_ptr (w_ptr),
        .o_gnt (w_pick_oh),
        .o_any (w_pick_any)
    );

    assign w_pick_idx = onehot_to_idx(w_pick_oh);
    assign w_timeout  = (TIMEOUT != '0) && (r_cnt == TIMEOUT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_done   <= '0;
            r_start  <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_gnt    <= w_gnt_d;
            r_done   <= w_done_d;
            r_start  <= w_start_d;
            r_x      <= w_x_d;
            r_y      <= w_y_d;
            r_colour <= w_colour_d;
            r_cnt    <= w_cnt_d;
            r_err    <= w_err_d;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_pick_any) w_next_state = S_START;
            S_START:   w_next_state = S_WAIT;
            S_WAIT:    if (draw_done || w_timeout) w_next_state = S_RELEASE;
            S_RELEASE: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; a draw_done coinciding with the
    // watchdog limit is a normal completion and does not raise the error.
    always_comb begin
        w_gnt_d    = r_gnt;
        w_done_d   = '0;
        w_start_d  = 1'b0;
        w_x_d      = r_x;
        w_y_d      = r_y;
        w_colour_d = r_colour;
        w_cnt_d    = r_cnt;
        w_err_d    = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_pick_any) begin
                    w_gnt_d    = w_pick_oh;
                    w_start_d  = 1'b1;
                    w_x_d      = req_x[w_pick_idx*COORD_W +: COORD_W];
                    w_y_d      = req_y[w_pick_idx*COORD_W +: COORD_W];
                    w_colour_d = req_colour[w_pick_idx*COLOUR_W +: COLOUR_W];
                end
            end
            S_START: w_cnt_d = '0;
            S_WAIT: begin
                w_cnt_d = r_cnt + 1'b1;
                if (draw_done) begin
                    w_done_d = r_gnt;
                end else if (w_timeout) begin
                    w_done_d = r_gnt;
                    w_err_d  = 1'b1;
                end
            end
            S_RELEASE: w_gnt_d = '0;
            default: ;
        endcase
    end

    assign gnt         = r_gnt;
    assign done        = r_done;
    assign draw_start  = r_start;
    assign draw_x      = r_x;
    assign draw_y      = r_y;
    assign draw_colour = r_colour;
    assign timeout_err = r_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_draw_arbiter.sv
// Randomized scoreboard bench for draw_arbiter (watchdog limit 8 cycles); honours
// DRAW_ARB_ROUNDROBIN_EN in its reference model.
module tb_draw_arbiter;

    localparam logic [19:0] TB_TIMEOUT = 20'd8;
    localparam int EXP_W = 4 + 10 + 10 + 3 + 1;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [3:0]  req = '0;
    logic [39:0] req_x = '0;
    logic [39:0] req_y = '0;
    logic [11:0] req_colour = '0;
    logic        draw_done = 1'b0;
    logic [3:0]  gnt, done;
    logic        draw_start, timeout_err;
    logic [9:0]  draw_x, draw_y;
    logic [2:0]  draw_colour;
    draw_arbiter_pkg::state_t dbg_state;

    draw_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req         (req),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_colour  (req_colour),
        .draw_done   (draw_done),
        .gnt         (gnt),
        .done        (done),
        .draw_start  (draw_start),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .draw_colour (draw_colour),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int passes = 0;
    int fails = 0;
    int start_count = 0;
    int txn_count = 0;
    logic [1:0] model_ptr = '0;
    logic       model_err = 1'b0;
    logic [9:0] mx[4];
    logic [9:0] my[4];
    logic [2:0] mc[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference winner: scan requesters starting at the priority pointer.
    function automatic int model_pick(input logic [3:0] r, input logic [1:0] p);
        for (int k = 0; k < 4; k++) begin
            if (r[(int'(p) + k) % 4]) return (int'(p) + k) % 4;
        end
        return 0;
    endfunction

    task automatic rand_coords();
        for (int i = 0; i < 4; i++) begin
            mx[i] = 10'($urandom_range(0, 1023));
            my[i] = 10'($urandom_range(0, 1023));
            mc[i] = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic drive_coords();
        for (int i = 0; i < 4; i++) begin
            req_x[10*i +: 10]     = mx[i];
            req_y[10*i +: 10]     = my[i];
            req_colour[3*i +: 3]  = mc[i];
        end
    endtask

    task automatic wait_start();
        int budget;
        budget = 0;
        while (!draw_start && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        check("draw_start_seen", draw_start, 1);
    endtask

    // d: WAIT-cycle index at which draw_done is sampled; d<0 means never.
    task automatic do_txn(input logic [3:0] rq, input int d, input bit drop);
        int w;
        int budget;
        @(negedge clk);
        req = rq;
        drive_coords();
        w = model_pick(rq, model_ptr);
        if (d < 0 || d > 8) model_err = 1'b1;
        exp_q.push_back({4'(1 << w), mx[w], my[w], mc[w], model_err});
`ifdef DRAW_ARB_ROUNDROBIN_EN
        model_ptr = 2'(w + 1);
`endif
        txn_count++;
        wait_start();
        for (int i = 0; i < 4; i++) begin
            req_x[10*i +: 10]    = 10'($urandom_range(0, 1023));
            req_y[10*i +: 10]    = 10'($urandom_range(0, 1023));
            req_colour[3*i +: 3] = 3'($urandom_range(0, 7));
        end
        if (drop) req = '0;
        if (d >= 0) begin
            repeat (d + 1) @(negedge clk);
            draw_done = 1'b1;
            @(negedge clk);
            draw_done = 1'b0;
        end
        budget = 0;
        while (gnt != 0 && budget < 30) begin
            @(negedge clk);
            budget++;
        end
        check("gnt_released", gnt, 0);
        req = '0;
    endtask

    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (resetn) begin
            check("gnt_onehot0", $onehot0(gnt), 1);
            if (dbg_state == draw_arbiter_pkg::S_IDLE) check("gnt_zero_in_idle", gnt, 0);
            if (draw_start) start_count++;
            if (done != 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_pkt", {done, draw_x, draw_y, draw_colour, timeout_err}, e);
                    check("gnt_matches_done", gnt, done);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        #1 resetn = 1'b0;
        #2;
        check("reset_outputs", {gnt, done, draw_start, draw_x, draw_y, draw_colour, timeout_err, dbg_state}, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Single request with fixed coordinates, draw_done three cycles after start
        rand_coords();
        mx[2] = 10'd100; my[2] = 10'd50; mc[2] = 3'd5;
        do_txn(4'b0100, 2, 1'b0);

        // Full contention with immediate completion
        for (int n = 0; n < 5; n++) begin
            rand_coords();
            do_txn(4'b1111, 0, 1'b0);
        end

        // draw_done exactly at the watchdog limit, then a real timeout
        rand_coords(); do_txn(4'b0001, 8, 1'b0);
        rand_coords(); do_txn(4'b1000, -1, 1'b0);
        // Late draw_done lands in RELEASE and is ignored; request dropped mid-flight
        rand_coords(); do_txn(4'b0010, 9, 1'b1);
        rand_coords(); do_txn(4'b0110, 1, 1'b0);

        // draw_done while idle must not produce anything
        @(negedge clk);
        draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_no_grant", gnt, 0);

        // Reset in the middle of a transaction
        rand_coords();
        req = 4'b0010;
        drive_coords();
        txn_count++;
        wait_start();
        repeat (3) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midreset_outputs", {gnt, done, draw_start, draw_x, draw_y, draw_colour, timeout_err, dbg_state}, 0);
        req = '0;
        model_ptr = '0;
        model_err = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        rand_coords();
        do_txn(4'b1010, 1, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            int d;
            d = $urandom_range(0, 10);
            if (d == 10) d = -1;
            rand_coords();
            do_txn(4'($urandom_range(1, 15)), d, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("start_pulses", start_count, txn_count);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/draw_arbiter.md
DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 20'd1024, watchdog limit in clk cycles for one draw; 0 disables the watchdog.
REQ-002 Ports: clk  in  1  system clock; all state changes on its rising edge.
REQ-003 Ports: resetn  in  1  asynchronous, active-low reset.
REQ-004 Ports: req  in  4  draw requests; bit0 loader, bit1 brick erase, bit2 ball, bit3 paddle.
REQ-005 Ports: req_x  in  40  packed x coordinates, 10 bits per requester, requester i at [10i+9:10i].
REQ-006 Ports: req_y  in  40  packed y coordinates, same packing as req_x.
REQ-007 Ports: req_colour  in  12  packed colours, 3 bits per requester.
REQ-008 Ports: draw_done  in  1  single-cycle completion pulse from the shared draw engine.
REQ-009 Ports: gnt  out  4  one-hot grant, held for the whole transaction.
REQ-010 Ports: done  out  4  one-cycle completion pulse to the granted requester.
REQ-011 Ports: draw_start  out  1  one-cycle start pulse to the draw engine.
REQ-012 Ports: draw_x, draw_y  out  10 each  latched coordinates of the granted requester.
REQ-013 Ports: draw_colour  out  3  latched colour of the granted requester.
REQ-014 Ports: timeout_err  out  1  sticky watchdog flag.

Function
REQ-015 FSM states: S_IDLE, S_START, S_WAIT, S_RELEASE; the state register and all outputs are registered.
REQ-016 S_IDLE: if any req bit is set, select a winner, latch its x/y/colour into draw_x/draw_y/draw_colour, set gnt, go to S_START; otherwise stay.
REQ-017 S_START: draw_start=1 for exactly one cycle; clear the watchdog counter; go to S_WAIT.
REQ-018 S_WAIT: the 20-bit counter increments each cycle; on draw_done go to S_RELEASE.
REQ-019 S_WAIT: with TIMEOUT!=0, if draw_done is absent when the counter equals TIMEOUT, set timeout_err and go to S_RELEASE.
REQ-020 draw_done and timeout in the same cycle count as normal completion; timeout_err is not set.
REQ-021 S_RELEASE: done[winner]=1 for one cycle; gnt clears on the next edge; update the priority pointer; return to S_IDLE.
REQ-022 Minimum request-to-done latency: 4 cycles (IDLE, START, WAIT with immediate draw_done, RELEASE); minimum spacing between back-to-back grants: 4 cycles.
REQ-023 draw_done outside S_WAIT is ignored.
REQ-024 Dropping req while granted does not abort; the transaction completes and done still pulses.
REQ-025 draw_x/draw_y/draw_colour stay stable from S_START until the next grant, independent of req_* changes.
REQ-026 gnt is zero or one-hot at all times, and is never asserted in S_IDLE.

Reset
REQ-027 resetn=0 asynchronously forces S_IDLE, gnt=0, done=0, draw_start=0, draw_x/draw_y=0, draw_colour=0, counter=0, pointer=0, timeout_err=0.
REQ-028 Reset mid-transaction abandons it; no done pulse is issued; arbitration restarts from pointer 0.
REQ-029 timeout_err clears only on reset.

Configuration
REQ-030 Macro DRAW_ARB_ROUNDROBIN_EN defined: round-robin; after granting i, priority order is i+1, i+2, ... mod 4.
REQ-031 Macro DRAW_ARB_ROUNDROBIN_EN undefined: fixed priority, lowest index wins (loader highest); the pointer is not implemented.

Structure
REQ-032 Requester indices, the TIMEOUT default and the state encodings are defined in the shared macros header next to BRICKDRAW/BRICKNUM.
REQ-033 One sub-module, draw_arb_pick: combinational winner select from req and pointer, with a one-hot output.

Verification
REQ-034 Single request: req=4'b0100, x=100, y=50, colour=3'b101, draw_done 3 cycles after draw_start -> gnt=4'b0100, draw_x=100, draw_y=50, draw_colour=5, done=4'b0100 one cycle.
REQ-035 Contention: req=4'b1111 held, draw_done immediate -> round-robin grants 0,1,2,3,0; fixed priority grants 0 every time.
REQ-036 Watchdog: TIMEOUT=8, no draw_done -> RELEASE after counter reaches 8, done pulses, timeout_err=1 and stays set.
REQ-037 Tie: TIMEOUT=8, draw_done in the same cycle the counter hits 8 -> done pulses, timeout_err=0.
REQ-038 Reset mid-S_WAIT with gnt=4'b0010 -> all outputs 0 immediately; no done pulse; with req=4'b1010 after reset, grant 1 (pointer 0).
